jkff_bank_seq: RTL and testbench

- Command sequencer for a bank of WIDTH jkff_sar flip-flops that share CLK.
- Accepts masked commands (clear, set, load, toggle-N, async clear/set) over a valid/ready handshake.
- Drives the bank's J/K vectors and its shared RST_N/SET pins.
- Checks the bank's Q feedback against an internally computed expected value, then reports done/err.

---
 rtl/jkff_bank_seq.sv | 203 ++++++++++++++++++++
 tb/tb_jkff_bank_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jkff_bank_seq.sv
// Sequencer for a shared-clock JK flop bank: masked clear/set/load/toggle/async commands over valid/ready.
// Latency: steps+1 cycles to done; define JKSEQ_VERIFY_EN to add a CHECK cycle comparing Q (steps+2).
// Backpressure: cmd_ready only in IDLE and outside reset; cmd_valid while busy is ignored, nothing is queued.
module jkff_bank_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             ff_rst_n,
    output logic             ff_set,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_ACLR   = 3'd5;
    localparam logic [2:0] OP_ASET   = 3'd6;
    localparam logic [2:0] OP_RSV    = 3'd7;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, steps;
    logic             ff_rst_n_q, ff_rst_n_d;
    logic             ff_set_q, ff_set_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

`ifdef JKSEQ_VERIFY_EN
    logic [WIDTH-1:0] exp_q, exp_d, exp_c;
    logic             rsv_q, rsv_d;

    // Expected bank value after the command, derived from the Q snapshot at accept.
    always_comb begin
        exp_c = Q;
        case (cmd_op)
            OP_CLEAR:  exp_c = Q & ~cmd_mask;
            OP_SET:    exp_c = Q | cmd_mask;
            OP_TOGGLE: exp_c = cmd_count[0] ? (Q ^ cmd_mask) : Q;
            OP_LOAD:   exp_c = (Q & ~cmd_mask) | (cmd_data & cmd_mask);
            OP_ACLR:   exp_c = '0;
            OP_ASET:   exp_c = '1;
            default:   exp_c = Q;
        endcase
    end
`else
    logic q_unused;
    assign q_unused = ^Q;
`endif

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        ff_rst_n_d = 1'b1;
        ff_set_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        steps      = '0;
`ifdef JKSEQ_VERIFY_EN
        exp_d      = exp_q;
        rsv_d      = rsv_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    j_d = '0;
                    k_d = '0;
`ifdef JKSEQ_VERIFY_EN
                    exp_d = exp_c;
                    rsv_d = (cmd_op == OP_RSV);
`endif
                    case (cmd_op)
                        OP_CLEAR: begin
                            k_d   = cmd_mask;
                            steps = CNT_W'(1);
                        end
                        OP_SET: begin
                            j_d   = cmd_mask;
                            steps = CNT_W'(1);
                        end
                        OP_TOGGLE: begin
                            j_d   = cmd_mask;
                            k_d   = cmd_mask;
                            steps = cmd_count;
                        end
                        OP_LOAD: begin
                            j_d   = cmd_data & cmd_mask;
                            k_d   = ~cmd_data & cmd_mask;
                            steps = CNT_W'(1);
                        end
                        OP_ACLR: begin
                            ff_rst_n_d = 1'b0;
                            steps      = CNT_W'(1);
                        end
                        OP_ASET: begin
                            ff_set_d = 1'b1;
                            steps    = CNT_W'(1);
                        end
                        OP_NOP, OP_RSV: steps = '0;
                        default:        steps = '0;
                    endcase
                    if (steps != '0) begin
                        state_d = DRIVE;
                        cnt_d   = steps;
                    end else begin
                        // Zero-step commands never touch the bank.
                        j_d = '0;
                        k_d = '0;
`ifdef JKSEQ_VERIFY_EN
                        state_d = CHECK;
`else
                        done_d = 1'b1;
                        err_d  = (cmd_op == OP_RSV);
`endif
                    end
                end
            end
            DRIVE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    j_d = '0;
                    k_d = '0;
`ifdef JKSEQ_VERIFY_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
`ifdef JKSEQ_VERIFY_EN
                done_d  = 1'b1;
                err_d   = rsv_q || (Q != exp_q);
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            ff_rst_n_q <= 1'b0;
            ff_set_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef JKSEQ_VERIFY_EN
            exp_q      <= '0;
            rsv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            ff_rst_n_q <= ff_rst_n_d;
            ff_set_q   <= ff_set_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef JKSEQ_VERIFY_EN
            exp_q      <= exp_d;
            rsv_q      <= rsv_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE) && !RST;
    assign J         = j_q;
    assign K         = k_q;
    assign ff_rst_n  = ff_rst_n_q;
    assign ff_set    = ff_set_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jkff_bank_seq.sv
// Bench for jkff_bank_seq: behavioural JK bank on the DUT pins, per-command predictions queued at accept,
// and a monitor that retires one prediction per done pulse. Expectations follow JKSEQ_VERIFY_EN.
module tb_jkff_bank_seq;
    localparam int W  = 8;
    localparam int CW = 8;
`ifdef JKSEQ_VERIFY_EN
    localparam int EXTRA  = 2;
    localparam bit VERIFY = 1'b1;
`else
    localparam int EXTRA  = 1;
    localparam bit VERIFY = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [W-1:0]  cmd_mask = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0]  Q, J, K;
    logic          cmd_ready, ff_rst_n, ff_set, busy, done, err;

    logic [W-1:0]  bank  = '0;
    logic [W-1:0]  stuck = '0;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            acc_cnt  = 0;

    typedef struct {
        int           lat;
        int           jk_cycles;
        logic [W-1:0] jp;
        logic [W-1:0] kp;
        int           rst_pulses;
        int           set_pulses;
        logic         e_err;
        logic [W-1:0] e_bank;
    } exp_t;

    exp_t sbq[$];

    always #5 CLK = ~CLK;

    jkff_bank_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .Q(Q), .J(J), .K(K), .ff_rst_n(ff_rst_n), .ff_set(ff_set),
        .busy(busy), .done(done), .err(err)
    );

    // The controlled bank: JK flops with async clear (RST_N) and async set.
    always @(posedge CLK or negedge ff_rst_n or posedge ff_set) begin
        if (!ff_rst_n)   bank <= '0;
        else if (ff_set) bank <= '1;
        else             bank <= (J & ~bank) | (~K & bank);
    end
    assign Q = bank & ~stuck;

    always @(posedge CLK) begin
        if (!RST && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] apply(input int op, input logic [W-1:0] b,
                                           input logic [W-1:0] m, input logic [W-1:0] d, input int cnt);
        case (op)
            1:       return b & ~m;
            2:       return b | m;
            3:       return (cnt % 2 == 1) ? (b ^ m) : b;
            4:       return (b & ~m) | (d & m);
            5:       return '0;
            6:       return '1;
            default: return b;
        endcase
    endfunction

    function automatic exp_t predict(input int op, input logic [W-1:0] m, input logic [W-1:0] d,
                                     input int cnt, input logic [W-1:0] b, input logic [W-1:0] st);
        exp_t e;
        int   steps;
        e.jp = '0;
        e.kp = '0;
        case (op)
            1:       begin steps = 1;   e.kp = m; end
            2:       begin steps = 1;   e.jp = m; end
            3:       begin steps = cnt; e.jp = m; e.kp = m; end
            4:       begin steps = 1;   e.jp = d & m; e.kp = ~d & m; end
            5, 6:    steps = 1;
            default: steps = 0;
        endcase
        e.jk_cycles  = ((e.jp | e.kp) != '0) ? steps : 0;
        e.rst_pulses = (op == 5) ? 1 : 0;
        e.set_pulses = (op == 6) ? 1 : 0;
        e.e_bank     = apply(op, b, m, d, cnt);
        e.lat        = steps + EXTRA;
        // The DUT only sees the stuck-filtered Q, both for its snapshot and for its check.
        e.e_err      = (op == 7) || (VERIFY && ((e.e_bank & ~st) != apply(op, b & ~st, m, d, cnt)));
        return e;
    endfunction

    initial begin : monitor
        int   cyc, jkc, rp, sp;
        exp_t e;
        cyc = 0; jkc = 0; rp = 0; sp = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                cyc = 0; jkc = 0; rp = 0; sp = 0;
                continue;
            end
            check("rst_set_exclusive", 32'(ff_set & ~ff_rst_n), 32'd0);
            if (sbq.size() == 0) begin
                cyc = 0; jkc = 0; rp = 0; sp = 0;
                if (done) check("unexpected_done", 32'(done), 32'd0);
                continue;
            end
            e = sbq[0];
            cyc++;
            if ((J | K) != '0) begin
                jkc++;
                check("jk_pattern", {16'd0, J, K}, {16'd0, e.jp, e.kp});
            end
            if (!ff_rst_n) rp++;
            if (ff_set)    sp++;
            if (cyc == e.lat && !done) check("done_on_time", 32'(done), 32'd1);
            if (done) begin
                void'(sbq.pop_front());
                check("latency",      cyc, e.lat);
                check("err",          32'(err), 32'(e.e_err));
                check("bank_q",       32'(bank), 32'(e.e_bank));
                check("jk_cycles",    jkc, e.jk_cycles);
                check("rst_n_pulses", rp, e.rst_pulses);
                check("set_pulses",   sp, e.set_pulses);
                check("busy_at_done", 32'(busy), 32'd0);
                check("ready_at_done", 32'(cmd_ready), 32'd1);
                cyc = 0; jkc = 0; rp = 0; sp = 0;
            end else begin
                check("busy_during", 32'(busy), 32'd1);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int guard = 0;
        @(negedge CLK);
        while (!cmd_ready && guard < 600) begin
            @(negedge CLK);
            guard++;
        end
        ok = cmd_ready;
        if (!ok) check("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input int op, input logic [W-1:0] m, input logic [W-1:0] d, input int cnt);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        cmd_op    = 3'(op);
        cmd_mask  = m;
        cmd_data  = d;
        cmd_count = CW'(cnt);
        cmd_valid = 1'b1;
        e = predict(op, m, d, cnt, bank, stuck);
        @(posedge CLK);
        sbq.push_back(e);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (sbq.size() != 0 && guard < 600) begin
            @(negedge CLK);
            guard++;
        end
        if (sbq.size() != 0) begin
            check("done_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   acc0, guard;
        bit   ok;
        exp_t e;

        #1 RST = 1'b1;
        #2;
        check("rst_J",        32'(J), 32'd0);
        check("rst_K",        32'(K), 32'd0);
        check("rst_ff_rst_n", 32'(ff_rst_n), 32'd0);
        check("rst_ff_set",   32'(ff_set), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        check("rst_ready",    32'(cmd_ready), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1 check("ff_rst_n_release", 32'(ff_rst_n), 32'd1);

        // Abort a long toggle in its fourth drive cycle.
        issue(3, 8'hFF, 8'h00, 10);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        sbq.delete();
        #1;
        check("abort_J",        32'(J), 32'd0);
        check("abort_K",        32'(K), 32'd0);
        check("abort_ff_rst_n", 32'(ff_rst_n), 32'd0);
        check("abort_busy",     32'(busy), 32'd0);
        check("abort_done",     32'(done), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_release_rst_n", 32'(ff_rst_n), 32'd1);
        check("abort_bank",          32'(Q), 32'h00);
        repeat (3) @(negedge CLK);

        issue(4, 8'hFF, 8'hA5, 0);  wait_done(); check("load_q",   32'(Q), 32'hA5);
        issue(3, 8'h0F, 8'h00, 3);  wait_done(); check("toggle_q", 32'(Q), 32'hAA);
        issue(1, 8'hF0, 8'h00, 0);  wait_done(); check("clear_q",  32'(Q), 32'h0A);
        issue(2, 8'h03, 8'h00, 0);  wait_done(); check("set_q",    32'(Q), 32'h0B);
        issue(6, 8'h00, 8'h00, 0);  wait_done(); check("aset_q",   32'(Q), 32'hFF);
        issue(5, 8'h00, 8'h00, 0);  wait_done(); check("aclr_q",   32'(Q), 32'h00);

        // Bit 0 of Q stuck at zero toward the DUT.
        stuck = 8'h01;
        issue(2, 8'h01, 8'h00, 0);  wait_done();
        stuck = 8'h00;

        // cmd_valid held through a busy toggle: exactly one accept.
        acc0 = acc_cnt;
        wait_ready(ok);
        if (ok) begin
            cmd_op = 3'd3; cmd_mask = 8'h3C; cmd_data = 8'h00; cmd_count = 8'd4;
            cmd_valid = 1'b1;
            e = predict(3, 8'h3C, 8'h00, 4, bank, stuck);
            @(posedge CLK);
            sbq.push_back(e);
            guard = 0;
            do begin
                @(negedge CLK);
                guard++;
            end while (!done && guard < 50);
            cmd_valid = 1'b0;
            wait_done();
            repeat (3) @(negedge CLK);
            check("single_accept", acc_cnt - acc0, 1);
        end

        issue(7, 8'hFF, 8'hFF, 5);   wait_done();
        issue(3, 8'hFF, 8'h00, 0);   wait_done();
        issue(0, 8'hFF, 8'h00, 0);   wait_done();
        issue(3, 8'h81, 8'h00, 255); wait_done();

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 7)), W'($urandom), W'($urandom), int'($urandom_range(0, 6)));
            wait_done();
        end

        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
